// File: rtl/node_packet_sink_pkg.sv
// Shared configuration for the packet sink: mesh size, packet layout, sink FSM states.
package node_packet_sink_pkg;

  localparam int unsigned X_NODES           = 4;
  localparam int unsigned Y_NODES           = 4;
  localparam int unsigned INPUT_QUEUE_DEPTH = 4;
  localparam int unsigned MAX_MEMORIES      = 4;

  localparam int unsigned XW = $clog2(X_NODES);
  localparam int unsigned YW = $clog2(Y_NODES);
  localparam int unsigned MW = $clog2(MAX_MEMORIES + 1);

  typedef struct packed {
    logic [XW-1:0]              x_source;
    logic [YW-1:0]              y_source;
    logic [XW-1:0]              x_dest;
    logic [YW-1:0]              y_dest;
    logic                       ant;
    logic                       backward;
    logic [31:0]                timestamp;
    logic [MW-1:0]              num_memories;
    logic [MAX_MEMORIES*XW-1:0] x_memory;
    logic [MAX_MEMORIES*YW-1:0] y_memory;
    logic [MAX_MEMORIES*XW-1:0] b_x_memory;
    logic [MAX_MEMORIES*YW-1:0] b_y_memory;
    logic [MW-1:0]              b_num_memories;
    logic [15:0]                payload;
  } packet_t;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StRespond
  } sink_state_e;

  // Saturating 16-bit increment shared by all event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/packet_fifo.sv
// Ejection buffer: power-of-two circular FIFO of packets with registered occupancy.
module packet_fifo
  import node_packet_sink_pkg::*;
#(
  parameter int unsigned DEPTH = INPUT_QUEUE_DEPTH,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push_i,
  input  packet_t         wdata_i,
  input  logic            pop_i,
  output packet_t         rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  packet_t         mem_q [DEPTH];
  packet_t         mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO or a pop from an empty one is silently dropped.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next-state: storage write, pointer advance, occupancy push minus pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/node_packet_sink.sv
// Packet sink for one mesh node: buffers ejected packets, keeps delivery statistics and
// turns forward ants addressed here into backward ants for re-injection.
module node_packet_sink
  import node_packet_sink_pkg::*;
#(
  parameter int          X_POS      = 0,
  parameter int          Y_POS      = 0,
  parameter int unsigned FIFO_DEPTH = INPUT_QUEUE_DEPTH
) (
  input  logic        clk,
  input  logic        reset_n,
  input  packet_t     i_data,
  input  logic        i_data_val,
  output logic        o_en,
  input  logic [31:0] i_now,
  output packet_t     o_resp,
  output logic        o_resp_val,
  input  logic        i_resp_en,
  output logic [15:0] o_rx_count,
  output logic [15:0] o_err_count,
  output logic [31:0] o_lat_sum,
  output logic [15:0] o_lat_max,
  output logic [15:0] o_ant_count
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [XW-1:0] XPos = XW'(X_POS);
  localparam logic [YW-1:0] YPos = YW'(Y_POS);

  sink_state_e     state_q, state_d;
  packet_t         held_q, held_d;
  packet_t         resp_q, resp_d;
  logic [15:0]     rx_q, rx_d;
  logic [15:0]     err_q, err_d;
  logic [31:0]     lat_sum_q, lat_sum_d;
  logic [15:0]     lat_max_q, lat_max_d;
  logic [15:0]     ant_q, ant_d;

  packet_t         fifo_rdata;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [CntW-1:0] fifo_count;
  logic            unused_fifo_full;

  logic [15:0]     lat;
  logic [32:0]     lat_sum_ext;
  logic            dest_match;

  // Ready depends only on the registered occupancy, never on i_data_val.
  assign o_en             = (fifo_count < CntW'(FIFO_DEPTH));
  assign fifo_pop         = (state_q == StIdle) && !fifo_empty;
  assign unused_fifo_full = fifo_full;

  packet_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (i_data_val && o_en),
    .wdata_i (i_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Latency wraps on the low 16 bits so a timestamp near rollover still measures correctly.
  assign lat         = i_now[15:0] - held_q.timestamp[15:0];
  assign lat_sum_ext = {1'b0, lat_sum_q} + {17'd0, lat};
  assign dest_match  = (held_q.x_dest == XPos) && (held_q.y_dest == YPos);

  // FSM next-state, statistics update and backward-ant construction.
  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    resp_d    = resp_q;
    rx_d      = rx_q;
    err_d     = err_q;
    lat_sum_d = lat_sum_q;
    lat_max_d = lat_max_q;
    ant_d     = ant_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          held_d  = fifo_rdata;
          state_d = StCheck;
        end
      end
      StCheck: begin
        rx_d      = sat_inc16(rx_q);
        lat_sum_d = lat_sum_ext[32] ? 32'hFFFF_FFFF : lat_sum_ext[31:0];
        lat_max_d = (lat > lat_max_q) ? lat : lat_max_q;
        if (!dest_match) begin
          err_d = sat_inc16(err_q);
        end
        if (held_q.ant && !held_q.backward && dest_match) begin
          resp_d                = held_q;
          resp_d.x_source       = held_q.x_dest;
          resp_d.y_source       = held_q.y_dest;
          resp_d.x_dest         = held_q.x_source;
          resp_d.y_dest         = held_q.y_source;
          resp_d.backward       = 1'b1;
          resp_d.b_x_memory     = held_q.x_memory;
          resp_d.b_y_memory     = held_q.y_memory;
          resp_d.b_num_memories = held_q.num_memories;
          resp_d.timestamp      = i_now;
          state_d               = StRespond;
        end else begin
          state_d = StIdle;
        end
      end
      StRespond: begin
        if (i_resp_en) begin
          ant_d   = sat_inc16(ant_q);
          resp_d  = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset drops any held packet without counting it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      held_q    <= '0;
      resp_q    <= '0;
      rx_q      <= '0;
      err_q     <= '0;
      lat_sum_q <= '0;
      lat_max_q <= '0;
      ant_q     <= '0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      resp_q    <= resp_d;
      rx_q      <= rx_d;
      err_q     <= err_d;
      lat_sum_q <= lat_sum_d;
      lat_max_q <= lat_max_d;
      ant_q     <= ant_d;
    end
  end

  assign o_resp_val  = (state_q == StRespond);
  assign o_resp      = o_resp_val ? resp_q : '0;
  assign o_rx_count  = rx_q;
  assign o_err_count = err_q;
  assign o_lat_sum   = lat_sum_q;
  assign o_lat_max   = lat_max_q;
  assign o_ant_count = ant_q;

endmodule

// File: tb/tb_node_packet_sink.sv
// Self-checking bench for node_packet_sink at node (0,0).
module tb_node_packet_sink;
  import node_packet_sink_pkg::*;

  localparam int unsigned DEPTH = INPUT_QUEUE_DEPTH;

  logic        clk;
  logic        reset_n;
  packet_t     i_data;
  logic        i_data_val;
  logic        o_en;
  logic [31:0] i_now;
  packet_t     o_resp;
  logic        o_resp_val;
  logic        i_resp_en;
  logic [15:0] o_rx_count, o_err_count, o_lat_max, o_ant_count;
  logic [31:0] o_lat_sum;

  node_packet_sink #(
    .X_POS      (0),
    .Y_POS      (0),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_data      (i_data),
    .i_data_val  (i_data_val),
    .o_en        (o_en),
    .i_now       (i_now),
    .o_resp      (o_resp),
    .o_resp_val  (o_resp_val),
    .i_resp_en   (i_resp_en),
    .o_rx_count  (o_rx_count),
    .o_err_count (o_err_count),
    .o_lat_sum   (o_lat_sum),
    .o_lat_max   (o_lat_max),
    .o_ant_count (o_ant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  packet_t exp_q[$];

  logic [15:0] m_rx, m_err, m_lat_max, m_ant;
  logic [31:0] m_lat_sum;

  function automatic packet_t mk_pkt(input int xs, input int ys, input int xd, input int yd,
                                     input logic ant, input logic bwd, input logic [31:0] ts,
                                     input int nm);
    packet_t p;
    p                = '0;
    p.x_source       = XW'(xs);
    p.y_source       = YW'(ys);
    p.x_dest         = XW'(xd);
    p.y_dest         = YW'(yd);
    p.ant            = ant;
    p.backward       = bwd;
    p.timestamp      = ts;
    p.num_memories   = MW'(nm);
    p.x_memory       = 8'hE4;
    p.y_memory       = 8'h1B;
    p.b_x_memory     = 8'h5A;
    p.b_y_memory     = 8'hC3;
    p.b_num_memories = MW'(1);
    p.payload        = ts[15:0] ^ 16'hA5A5;
    return p;
  endfunction

  function automatic packet_t exp_resp(input packet_t p, input logic [31:0] now);
    packet_t r;
    r                = p;
    r.x_source       = p.x_dest;
    r.y_source       = p.y_dest;
    r.x_dest         = p.x_source;
    r.y_dest         = p.y_source;
    r.backward       = 1'b1;
    r.b_x_memory     = p.x_memory;
    r.b_y_memory     = p.y_memory;
    r.b_num_memories = p.num_memories;
    r.timestamp      = now;
    return r;
  endfunction

  task automatic model_consume(input packet_t p, input logic [31:0] now);
    logic [15:0] l;
    l         = now[15:0] - p.timestamp[15:0];
    m_rx      = m_rx + 16'd1;
    m_lat_sum = m_lat_sum + {16'd0, l};
    if (l > m_lat_max) m_lat_max = l;
    if (p.x_dest != '0 || p.y_dest != '0) m_err = m_err + 16'd1;
  endtask

  task automatic model_clear();
    m_rx = '0; m_err = '0; m_lat_sum = '0; m_lat_max = '0; m_ant = '0;
  endtask

  task automatic send(input packet_t p);
    @(negedge clk);
    i_data     = p;
    i_data_val = 1'b1;
    @(negedge clk);
    i_data_val = 1'b0;
    i_data     = '0;
  endtask

  task automatic wait_resp(input string name);
    int waited;
    waited = 0;
    while (!o_resp_val && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (o_resp_val !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: o_resp_val=%b after %0d cycles, required 1", name, o_resp_val, waited);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_data = '0; i_data_val = 1'b0; i_now = '0; i_resp_en = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_en !== 1'b1) begin
      miscompares++; $display("FAIL reset_o_en: got %b, required 1", o_en);
    end
    vectors++;
    if (o_resp_val !== 1'b0 || o_resp !== '0) begin
      miscompares++;
      $display("FAIL reset_resp: val=%b resp=%h, required 0/0", o_resp_val, o_resp);
    end
    vectors++;
    if ({o_rx_count, o_err_count, o_lat_sum, o_lat_max, o_ant_count} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got %h, required 0",
               {o_rx_count, o_err_count, o_lat_sum, o_lat_max, o_ant_count});
    end
  endtask

  task automatic test_single();
    packet_t p;
    int seen;
    i_now = 32'd110;
    p = mk_pkt(3, 3, 0, 0, 1'b0, 1'b0, 32'd100, 2);
    model_consume(p, i_now);
    send(p);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_resp_val) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("FAIL single_noresp: o_resp_val seen %0d cycles, required 0", seen);
    end
    vectors++;
    if (o_rx_count !== 16'd1 || o_err_count !== 16'd0) begin
      miscompares++;
      $display("FAIL single_rx_err: rx=%0d err=%0d, required 1/0", o_rx_count, o_err_count);
    end
    vectors++;
    if (o_lat_sum !== 32'd10 || o_lat_max !== 16'd10) begin
      miscompares++;
      $display("FAIL single_lat: sum=%0d max=%0d, required 10/10", o_lat_sum, o_lat_max);
    end
  endtask

  task automatic test_err_dest();
    packet_t p;
    int seen;
    i_now = 32'd203;
    p = mk_pkt(2, 2, 1, 0, 1'b1, 1'b0, 32'd200, 1);
    model_consume(p, i_now);
    send(p);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_resp_val) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("FAIL err_noresp: o_resp_val seen %0d cycles, required 0", seen);
    end
    vectors++;
    if (o_err_count !== 16'd1 || o_rx_count !== 16'd2) begin
      miscompares++;
      $display("FAIL err_counts: err=%0d rx=%0d, required 1/2", o_err_count, o_rx_count);
    end
  endtask

  task automatic test_lat_wrap();
    packet_t p;
    i_now = 32'h00AB_0005;
    p = mk_pkt(1, 1, 0, 0, 1'b0, 1'b0, 32'h1234_FFF0, 0);
    model_consume(p, i_now);
    send(p);
    repeat (6) @(negedge clk);
    vectors++;
    if (o_lat_max !== 16'h0015) begin
      miscompares++; $display("FAIL lat_wrap_max: got %h, required 0015", o_lat_max);
    end
    vectors++;
    if (o_lat_sum !== m_lat_sum) begin
      miscompares++; $display("FAIL lat_wrap_sum: got %0d, required %0d", o_lat_sum, m_lat_sum);
    end
  endtask

  task automatic test_ant();
    packet_t p, first, e;
    int stable_bad;
    i_now = 32'd500;
    i_resp_en = 1'b0;
    p = mk_pkt(2, 1, 0, 0, 1'b1, 1'b0, 32'd480, 3);
    exp_q.push_back(exp_resp(p, i_now));
    model_consume(p, i_now);
    send(p);
    wait_resp("ant_wait");
    first = o_resp;
    e = exp_q.pop_front();
    vectors++;
    if (o_resp !== e) begin
      miscompares++; $display("FAIL ant_resp: got %h, required %h", o_resp, e);
    end
    vectors++;
    if (o_resp.x_dest !== XW'(2) || o_resp.y_dest !== YW'(1) || o_resp.backward !== 1'b1 ||
        o_resp.b_num_memories !== MW'(3)) begin
      miscompares++;
      $display("FAIL ant_fields: dest=(%0d,%0d) bwd=%b bnum=%0d, required (2,1) 1 3",
               o_resp.x_dest, o_resp.y_dest, o_resp.backward, o_resp.b_num_memories);
    end
    stable_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_resp_val !== 1'b1 || o_resp !== first) stable_bad++;
    end
    vectors++;
    if (stable_bad != 0) begin
      miscompares++; $display("FAIL ant_stable: %0d unstable cycles, required 0", stable_bad);
    end
    vectors++;
    if (o_ant_count !== 16'd0) begin
      miscompares++; $display("FAIL ant_count_early: got %0d, required 0", o_ant_count);
    end
    i_resp_en = 1'b1;
    m_ant = m_ant + 16'd1;
    @(negedge clk);
    i_resp_en = 1'b0;
    vectors++;
    if (o_resp_val !== 1'b0 || o_resp !== '0) begin
      miscompares++;
      $display("FAIL ant_release: val=%b resp=%h, required 0/0", o_resp_val, o_resp);
    end
    vectors++;
    if ({o_rx_count, o_err_count, o_lat_sum, o_lat_max, o_ant_count} !==
        {m_rx, m_err, m_lat_sum, m_lat_max, m_ant}) begin
      miscompares++;
      $display("FAIL ant_counters: got %h, required %h",
               {o_rx_count, o_err_count, o_lat_sum, o_lat_max, o_ant_count},
               {m_rx, m_err, m_lat_sum, m_lat_max, m_ant});
    end
  endtask

  task automatic test_back_to_back();
    packet_t a, p, e;
    int accepted;
    i_now = 32'd1000;
    i_resp_en = 1'b0;
    a = mk_pkt(1, 2, 0, 0, 1'b1, 1'b0, 32'd990, 2);
    exp_q.push_back(exp_resp(a, i_now));
    model_consume(a, i_now);
    send(a);
    wait_resp("burst_ant_wait");
    // FSM parked in RESPOND, so nothing drains while the burst arrives.
    accepted = 0;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      p = mk_pkt(3, 0, 0, 0, (i == 1), (i == 1), 32'd999 - 32'(i), 1);
      i_data     = p;
      i_data_val = 1'b1;
      if (o_en) begin
        accepted++;
        model_consume(p, i_now);
      end
      @(negedge clk);
    end
    i_data_val = 1'b0;
    i_data     = '0;
    vectors++;
    if (accepted != int'(DEPTH)) begin
      miscompares++; $display("FAIL burst_accepts: got %0d, required %0d", accepted, DEPTH);
    end
    vectors++;
    if (o_en !== 1'b0) begin
      miscompares++; $display("FAIL burst_full_o_en: got %b, required 0", o_en);
    end
    e = exp_q.pop_front();
    vectors++;
    if (o_resp_val !== 1'b1 || o_resp !== e) begin
      miscompares++;
      $display("FAIL burst_resp: val=%b got %h, required 1 %h", o_resp_val, o_resp, e);
    end
    i_resp_en = 1'b1;
    m_ant = m_ant + 16'd1;
    repeat (4 * DEPTH + 10) @(negedge clk);
    i_resp_en = 1'b0;
    vectors++;
    if (o_en !== 1'b1 || o_resp_val !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_drain: o_en=%b val=%b, required 1/0", o_en, o_resp_val);
    end
    vectors++;
    if ({o_rx_count, o_err_count, o_lat_sum, o_lat_max, o_ant_count} !==
        {m_rx, m_err, m_lat_sum, m_lat_max, m_ant}) begin
      miscompares++;
      $display("FAIL burst_counters: got %h, required %h",
               {o_rx_count, o_err_count, o_lat_sum, o_lat_max, o_ant_count},
               {m_rx, m_err, m_lat_sum, m_lat_max, m_ant});
    end
  endtask

  task automatic test_reset_respond();
    packet_t p;
    i_now = 32'd50;
    i_resp_en = 1'b0;
    p = mk_pkt(3, 2, 0, 0, 1'b1, 1'b0, 32'd40, 1);
    send(p);
    wait_resp("rst_ant_wait");
    // Park two more packets in the FIFO; reset must discard them.
    i_data = mk_pkt(1, 1, 0, 0, 1'b0, 1'b0, 32'd45, 0);
    i_data_val = 1'b1;
    repeat (2) @(negedge clk);
    i_data_val = 1'b0;
    i_data = '0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    vectors++;
    if (o_resp_val !== 1'b0 || o_resp !== '0 || o_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_respond: val=%b resp=%h o_en=%b, required 0/0/1",
               o_resp_val, o_resp, o_en);
    end
    vectors++;
    if ({o_rx_count, o_err_count, o_lat_sum, o_lat_max, o_ant_count} !== 96'd0) begin
      miscompares++;
      $display("FAIL rst_counters: got %h, required 0",
               {o_rx_count, o_err_count, o_lat_sum, o_lat_max, o_ant_count});
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (o_rx_count !== m_rx || o_resp_val !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_discard: rx=%0d val=%b, required %0d/0", o_rx_count, o_resp_val, m_rx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_err_dest();
    test_lat_wrap();
    test_ant();
    test_back_to_back();
    test_reset_respond();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/node_packet_sink.md
NODE_PACKET_SINK -- requirements
Module: node_packet_sink

Interface
REQ-001 SHALL have parameter X_POS, default 0, X coordinate of the attached network node.
REQ-002 SHALL have parameter Y_POS, default 0, Y coordinate of the attached network node.
REQ-003 SHALL have parameter FIFO_DEPTH, default `INPUT_QUEUE_DEPTH, ejection buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_data  input  packet_t  packet ejected by network node.
REQ-007 SHALL have port i_data_val  input  1  i_data valid.
REQ-008 SHALL have port o_en  output  1  sink ready; drives the network's o_en for this node.
REQ-009 SHALL have port i_now  input  32  free-running system time in cycles.
REQ-010 SHALL have port o_resp  output  packet_t  backward ant for re-injection.
REQ-011 SHALL have port o_resp_val  output  1  o_resp valid.
REQ-012 SHALL have port i_resp_en  input  1  network accepts o_resp this cycle.
REQ-013 SHALL have port o_rx_count  output  16  packets consumed.
REQ-014 SHALL have port o_err_count  output  16  packets whose dest != (X_POS,Y_POS).
REQ-015 SHALL have port o_lat_sum  output  32  sum of latencies of consumed packets.
REQ-016 SHALL have port o_lat_max  output  16  maximum latency observed.
REQ-017 SHALL have port o_ant_count  output  16  backward ants emitted.

Function
REQ-018 SHALL accept a packet when i_data_val && o_en on a posedge, and only then.
REQ-019 SHALL drive o_en = (fifo count < FIFO_DEPTH) from registered count only; no combinational path from i_data_val.
REQ-020 SHALL allow push and pop in the same cycle, including when full (push rejected, o_en=0) and when empty (no pop); count changes by push minus pop.
REQ-021 SHALL implement FSM IDLE -> CHECK -> (RESPOND | IDLE); RESPOND -> IDLE on i_resp_en.
REQ-022 IDLE: if FIFO non-empty, pop head into a holding register and go to CHECK; else stay.
REQ-023 CHECK (1 cycle): lat = (i_now - timestamp) mod 2^16 computed on low 16 bits; rx_count+1; lat_sum+lat; lat_max=max; err_count+1 if x_dest!=X_POS or y_dest!=Y_POS.
REQ-024 CHECK: if ant=1, backward=0 and dest matches, go to RESPOND; otherwise go to IDLE.
REQ-025 RESPOND: o_resp = held packet with source/dest swapped, backward=1, b_x_memory/b_y_memory/b_num_memories = x_memory/y_memory/num_memories, timestamp=i_now at RESPOND entry; o_resp_val=1.
REQ-026 o_resp and o_resp_val SHALL stay stable until i_resp_en=1; transfer at the posedge with both high; o_ant_count+1 then.
REQ-027 All counters SHALL saturate at all-ones; o_lat_sum saturates at 2^32-1.
REQ-028 Minimum per-packet service: 2 cycles (non-ant), 3 cycles (ant, i_resp_en=1 immediately).
REQ-029 o_resp SHALL be 0 whenever o_resp_val=0.

Reset
REQ-030 On reset_n=0 at posedge: FIFO empty, FSM IDLE, all counters 0, o_resp_val=0, o_resp=0; o_en=1 from the first cycle after reset.
REQ-031 Reset mid-RESPOND or mid-CHECK SHALL discard held packet and FIFO contents without counting them.

Structure
REQ-032 packet_t, `X_NODES/`Y_NODES and the FSM state enum SHALL live in the shared config package.
REQ-033 FIFO SHALL be sub-module packet_fifo (parameter DEPTH, push/pop/full/empty/count), instantiated once.

Verification
REQ-034 Single packet dest=(X_POS,Y_POS), ant=0, timestamp=100, i_now=110 at CHECK -> rx=1, lat_sum=10, lat_max=10, err=0, no o_resp_val.
REQ-035 Burst of FIFO_DEPTH+2 back-to-back valids with FSM throttled -> o_en=0 after FIFO_DEPTH accepts, extra packets not counted, all accepted drained.
REQ-036 Forward ant source=(2,1), dest=(0,0), num_memories=3, i_resp_en held 0 for 5 cycles -> o_resp stable, dest=(2,1), backward=1, b_num_memories=3; ant_count=1 after i_resp_en.
REQ-037 Packet dest=(1,0) at node (0,0) -> err_count=1, rx_count=1, no response.
REQ-038 timestamp low 16 bits=0xFFF0, i_now low 16 bits=0x0005 -> lat=0x15.
REQ-039 Assert reset_n=0 during RESPOND -> next cycle o_resp_val=0, counters 0, o_en=1.
